dzielnik: RTL and testbench
===========================

Name: dzielnik

Overview:
- Clock divider for the real-time clock design.
- Derives a slow 50%-duty square wave `div_clk` from the system clock `clk_i`.
  - Normal mode: 1 Hz seconds base.
  - Test mode, selected by `button_test_i`: much faster output, so the clock chain can be exercised quickly.
- Sits between the board clock and the seconds/minutes/hours counters.

Parameters:
- CLK_FREQ_HZ, 50_000_000: input clock frequency.
- OUT_FREQ_HZ, 1: normal-mode output frequency.
- TEST_DIV, 10: test-mode full output period in `clk_i` cycles. Must be even and ≥2.
- SYNC_STAGES, 2: synchronizer depth for `button_test_i`. Must be ≥2.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-low reset (0 = reset).
- button_test_i  input  1  asynchronous level; 1 = test mode, 0 = normal mode.
- div_clk  output  1  divided square wave, registered.

Behaviour:
- Derived constants:
  - NORM_HALF = CLK_FREQ_HZ/(2*OUT_FREQ_HZ).
  - TEST_HALF = TEST_DIV/2.
  - Counter width CW = $clog2(max(NORM_HALF, TEST_HALF)), minimum 1.
- Elaboration-time check: error if NORM_HALF < 1 or TEST_DIV is odd or <2.
- Reset (rst_i==0 at a rising edge):
  - counter = 0, div_clk = 0.
  - All synchronizer flops = 0; registered mode = normal.
  - Reset dominates every other condition.
- Mode synchronizer:
  - `button_test_i` passes through a SYNC_STAGES flop chain, giving `test_mode`.
  - Latency is SYNC_STAGES cycles from input change to `test_mode` change.
  - No debounce; the input is a level.
- Ratio select: half = test_mode ? TEST_HALF : NORM_HALF.
- Counting, each non-reset cycle:
  - If counter >= half-1: counter <= 0 and div_clk <= ~div_clk.
  - Otherwise: counter <= counter+1.
  - The `>=` comparison guarantees wrap even if counter exceeds the new half after a mode change.
- Output timing:
  - div_clk period = 2*half cycles, duty exactly 50%.
  - First rising edge of div_clk occurs `half` cycles after the first non-reset edge.
- Mode change:
  - A registered copy `mode_q` of `test_mode` is kept.
  - In a cycle where test_mode != mode_q: counter <= 0, div_clk holds its level, mode_q <= test_mode.
  - The new half-period then runs in full from 0, so there is no runt pulse shorter than the new half.
- Reset mid-operation: counter and output clear on the next edge, regardless of phase or mode.
- Usage constraint: div_clk is a registered signal. Downstream logic uses it as a clock-enable via edge detect in the clk_i domain, not as a clock.

Decomposition:
- Package `dzielnik_pkg`:
  - Default constants DEF_CLK_FREQ_HZ and DEF_TEST_DIV.
  - Function `half_period(clk_hz, out_hz)`.
  - Width helper `cnt_width(a,b)`.
- Sub-module `dzielnik_sync`: parameterized N-stage level synchronizer with synchronous active-low reset. Instantiated once for `button_test_i`.
- Top `dzielnik`: counter, mode register, toggle flop.

Test Plan (bench overrides CLK_FREQ_HZ=20, OUT_FREQ_HZ=1, TEST_DIV=4, SYNC_STAGES=2 → NORM_HALF=10, TEST_HALF=2; clk period 20 ns):
- Hold rst_i=0 for 37 cycles with clk toggling → div_clk stays 0 and internal counter stays 0 throughout.
- Release rst_i=1, button_test_i=0 → div_clk rises 10 cycles after release. Period then 20 cycles, high 10 / low 10, checked over ≥3 periods.
- Set button_test_i=1 mid-period → after 2 sync cycles plus 1 restart cycle, toggles every 2 cycles (period 4). No high or low phase shorter than 2 cycles at the switch.
- Clear button_test_i=0 → same latency, then period returns to 20 with no runt phase; the level at the switch is preserved.
- Assert rst_i=0 while div_clk=1 in test mode → div_clk=0 on the next edge. After release, normal mode resumes with the first rise 10 cycles later.
- Pulse button_test_i high for 1 cycle between clock edges → synchronizer output changes for at most that pulse width. The divider restarts its count each time the mode flips and no X ever appears on div_clk.

Source files
------------

// File: rtl/dzielnik_pkg.sv
// Shared constants and elaboration helpers for the dzielnik clock divider.
package dzielnik_pkg;

    localparam int DEF_CLK_FREQ_HZ = 50_000_000;
    localparam int DEF_TEST_DIV    = 10;

    // Half output period in input clock cycles.
    function automatic int half_period(input int clk_hz, input int out_hz);
        return clk_hz / (2 * out_hz);
    endfunction

    // Counter width able to hold max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dzielnik_sync.sv
// N-stage level synchronizer with synchronous active-low reset.
module dzielnik_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous level through the flop chain; reset clears every stage.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/dzielnik.sv
// Clock divider: 50% duty square wave, 1 Hz normally, fast rate in test mode.
// div_clk is registered and meant to be edge-detected in the clk_i domain.
module dzielnik
    import dzielnik_pkg::*;
#(
    parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
    parameter int OUT_FREQ_HZ = 1,
    parameter int TEST_DIV    = DEF_TEST_DIV,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic button_test_i,
    output logic div_clk
);

    localparam int NORM_HALF = half_period(CLK_FREQ_HZ, OUT_FREQ_HZ);
    localparam int TEST_HALF = TEST_DIV / 2;
    localparam int CW        = cnt_width(NORM_HALF, TEST_HALF);

    localparam logic [CW-1:0] NORM_LAST = CW'(NORM_HALF - 1);
    localparam logic [CW-1:0] TEST_LAST = CW'(TEST_HALF - 1);

    if (NORM_HALF < 1 || (TEST_DIV % 2) != 0 || TEST_DIV < 2 || SYNC_STAGES < 2) begin : g_bad_params
        $error("dzielnik: invalid parameters (NORM_HALF<1, TEST_DIV odd/<2 or SYNC_STAGES<2)");
    end

    logic          w_test_mode;
    logic [CW-1:0] w_last;
    logic [CW-1:0] r_cnt;
    logic          r_mode;
    logic          r_div;

    dzielnik_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk_i),
        .i_rst_n (rst_i),
        .i_d     (button_test_i),
        .o_q     (w_test_mode)
    );

    assign w_last = w_test_mode ? TEST_LAST : NORM_LAST;

    // Count half periods and toggle; a mode flip restarts the count with the level held
    // so the first phase in the new mode is a full half period.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_mode <= 1'b0;
        end else if (w_test_mode != r_mode) begin
            r_mode <= w_test_mode;
            r_cnt  <= '0;
        end else if (r_cnt >= w_last) begin
            r_cnt  <= '0;
            r_div  <= ~r_div;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    assign div_clk = r_div;

endmodule

// File: tb/tb_dzielnik.sv
// Randomized self-checking bench for dzielnik against a closed-form timing model.
module tb_dzielnik;

    localparam int CLK_HZ = 20;
    localparam int OUT_HZ = 1;
    localparam int TDIV   = 4;
    localparam int S      = 2;
    localparam int NH     = CLK_HZ / (2 * OUT_HZ);
    localparam int TH     = TDIV / 2;
    localparam int HMAX   = 4096;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic button_test_i = 1'b0;
    logic div_clk;

    dzielnik #(
        .CLK_FREQ_HZ (CLK_HZ),
        .OUT_FREQ_HZ (OUT_HZ),
        .TEST_DIV    (TDIV),
        .SYNC_STAGES (S)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .button_test_i (button_test_i),
        .div_clk       (div_clk)
    );

    always #10 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    endtask

    // Reference model: the output level is a closed-form function of the number of
    // edges since the last restart (reset release or mode switch), the level at that
    // restart and the half period of the active mode.
    int   k        = 0;
    int   last_rst = -100;
    int   e0       = 0;
    logic lvl0     = 1'b0;
    logic mq       = 1'b0;
    logic exp_div  = 1'b0;
    bit   in_rst   = 1'b1;
    bit   hist [0:HMAX-1];

    always @(posedge clk_i) begin
        logic tm;
        int   half;
        if (!rst_i) begin
            exp_div  = 1'b0;
            e0       = k;
            lvl0     = 1'b0;
            mq       = 1'b0;
            last_rst = k;
            in_rst   = 1'b1;
            if (k < HMAX) hist[k] = 1'b0;
        end else begin
            in_rst = 1'b0;
            if (k < HMAX) hist[k] = button_test_i;
            // Mode seen this edge: button sampled S edges ago, unless a reset
            // cleared the chain since then.
            tm = (k >= S && last_rst <= k - S && k - S < HMAX) ? hist[k - S] : 1'b0;
            if (tm != mq) begin
                mq   = tm;
                e0   = k;
                lvl0 = exp_div;
            end else begin
                half    = mq ? TH : NH;
                exp_div = lvl0 ^ ((((k - e0) / half) % 2) == 1);
            end
        end
        k++;
    end

    always @(negedge clk_i) begin
        chk("div_known", {31'd0, $isunknown(div_clk)}, 32'd0);
        chk("div_model", {31'd0, div_clk}, {31'd0, exp_div});
        if (in_rst) chk("cnt_in_rst", 32'(dut.r_cnt), 32'd0);
    end

    // Cycles until div_clk differs from its current level (bounded).
    task automatic measure_phase(output int n);
        logic lvl;
        lvl = div_clk;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (div_clk === lvl && n < 100);
    endtask

    // Cycles until div_clk reaches lvl (bounded).
    task automatic wait_level(input logic lvl, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (div_clk !== lvl && n < bound);
    endtask

    initial begin
        int n;
        int r;

        // Long reset with clock running.
        rst_i = 1'b0;
        button_test_i = 1'b0;
        repeat (37) @(negedge clk_i);
        chk("rst_div", {31'd0, div_clk}, 32'd0);

        // Normal mode: first rise 10 cycles after release, then 10/10 phases.
        rst_i = 1'b1;
        wait_level(1'b1, 50, n);
        chk("first_rise", n, NH);
        for (int i = 0; i < 6; i++) begin
            measure_phase(n);
            chk("norm_phase", n, NH);
        end

        // Switch to test mode mid-period.
        repeat (4) @(negedge clk_i);
        button_test_i = 1'b1;
        repeat (20) @(negedge clk_i);
        measure_phase(n);
        for (int i = 0; i < 6; i++) begin
            measure_phase(n);
            chk("test_phase", n, TH);
        end

        // Back to normal mode.
        @(negedge clk_i);
        button_test_i = 1'b0;
        repeat (30) @(negedge clk_i);
        measure_phase(n);
        for (int i = 0; i < 4; i++) begin
            measure_phase(n);
            chk("norm_phase2", n, NH);
        end

        // Reset while high in test mode.
        button_test_i = 1'b1;
        repeat (10) @(negedge clk_i);
        wait_level(1'b1, 20, n);
        chk("test_high_seen", {31'd0, div_clk}, 32'd1);
        rst_i = 1'b0;
        button_test_i = 1'b0;
        @(negedge clk_i);
        chk("rst_clears", {31'd0, div_clk}, 32'd0);
        rst_i = 1'b1;
        wait_level(1'b1, 50, n);
        chk("rst_rise", n, NH);

        // Random mode flips, single-cycle pulses, sub-cycle glitches and resets.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            rst_i = 1'b1;
            r = int'($urandom_range(0, 63));
            if (r < 3) begin
                button_test_i = ~button_test_i;
            end else if (r == 7) begin
                rst_i = 1'b0;
            end else if (r == 8 && !button_test_i) begin
                #2 button_test_i = 1'b1;
                #4 button_test_i = 1'b0;
            end else if (r == 9 && !button_test_i) begin
                button_test_i = 1'b1;
                @(negedge clk_i);
                button_test_i = 1'b0;
            end
        end
        rst_i = 1'b1;
        repeat (5) @(negedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
